// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
// Shared types and constants for the MAC sequencer:
//   DATA_W    operand / result width
//   LEN_W     command length field width (cmd_len = 0 encodes 256 products)
//   state_t   sequencer FSM states
//   tag_t     per-beat tag carried alongside the DSP pipeline {valid, last}
// -----------------------------------------------------------------------------
package mac_seq_pkg;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, last: 1'b0};

    // A tag is only marked last when it actually carries a beat.
    function automatic tag_t make_tag(input logic beat, input logic last);
        tag_t t;
        t.valid = beat;
        t.last  = beat & last;
        return t;
    endfunction

endpackage

// File: rtl/mac_seq_tagpipe.sv
// -----------------------------------------------------------------------------
// mac_seq_tagpipe
// Two-stage tag shift register that follows each accepted operand beat through
// the DSP pipeline (operand regs -> multiplier -> accumulator) and decodes the
// per-stage DSP enables.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   beat    in   operand beat taken this cycle (operands enter the DSP regs)
//   last    in   this beat is the final product of the command
//   flush   in   drop every in-flight tag and mask the decoded enables
//   men     out  multiplier enable (tag in stage 1)
//   sen     out  accumulate enable (non-last tag in stage 2)
//   sreset  out  final add + result latch + accumulator clear (last tag in stage 2)
// -----------------------------------------------------------------------------
module mac_seq_tagpipe
    import mac_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic beat,
    input  logic last,
    input  logic flush,
    output logic men,
    output logic sen,
    output logic sreset
);

    tag_t p1;
    tag_t p2;

    // NOTE: registers are written with non-blocking assignments so p2 takes the
    // old p1 on the same edge; blocking here would collapse the two stages.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            p1 <= TAG_NONE;
            p2 <= TAG_NONE;
        end else begin
            p1 <= make_tag(beat, last);
            p2 <= p1;
        end
    end

    // Stage 2 carries exactly one tag, so sen and sreset are mutually exclusive
    // by construction. A flush also masks the enables in its own cycle so no
    // pending product reaches the accumulator while it is being cleared.
    // NOTE: every output gets a default first so the combinational block can
    // never infer a latch if a branch is added later.
    always_comb begin
        men    = 1'b0;
        sen    = 1'b0;
        sreset = 1'b0;
        if (!flush) begin
            men    = p1.valid;
            sen    = p2.valid & ~p2.last;
            sreset = p2.valid &  p2.last;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
// Sequences a K-product multiply-accumulate on an external DSP MAC block.
// A command supplies K (cmd_len, 0 = 256); K operand pairs are then streamed
// into the DSP, the tag pipeline steps the multiplier / accumulator enables, and
// the DSP result is presented on the result handshake until consumed.
//
// Ports
//   clk, rst_n                sole clock; synchronous active-low reset
//   cmd_valid/cmd_ready       command handshake, cmd_len = product count K
//   in_valid/in_ready         operand beat handshake, a_in/b_in signed operands
//   a_value, b_value          operands to the DSP (0 when no beat)
//   aen, ben                  DSP operand register enables (the beat)
//   men, sen, sreset          DSP multiply / accumulate / final-add+clear
//   start                     DSP accumulator clear (command accept or abort)
//   s_out, sat                DSP result and saturation flag
//   res_valid/res_ready       result handshake, res_data/res_sat pass-through
//   abort                     only with MAC_SEQ_ABORT_EN: drop the command in
//                             STREAM or DRAIN and clear the DSP accumulator
//
// Configuration macro: MAC_SEQ_ABORT_EN (undefined by default).
// -----------------------------------------------------------------------------
module mac_sequencer
    import mac_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,

    output logic [DATA_W-1:0] a_value,
    output logic [DATA_W-1:0] b_value,
    output logic              aen,
    output logic              ben,
    output logic              men,
    output logic              sen,
    output logic              start,
    output logic              sreset,

    input  logic [DATA_W-1:0] s_out,
    input  logic              sat,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_sat
`ifdef MAC_SEQ_ABORT_EN
    ,
    input  logic              abort
`endif
);

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic               cmd_ready_q;
    logic               in_ready_q;
    logic               res_valid_q;

    logic               accept;
    logic               beat;
    logic               last_beat;
    logic               abort_hit;

`ifdef MAC_SEQ_ABORT_EN
    // Abort only means something while products are in flight.
    assign abort_hit = abort && ((state == STREAM) || (state == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // Handshake decodes. The ready flags are registered and mirror the state,
    // so an accept or beat is a pure AND of registered ready and valid.
    always_comb begin
        accept    = cmd_valid & cmd_ready_q;
        beat      = in_valid & in_ready_q & ~abort_hit;
        last_beat = beat & (remaining == '0);
    end

    // DSP operand path: operands are forwarded only on a beat so the DSP
    // operand registers never see stale bus values.
    always_comb begin
        aen     = beat;
        ben     = beat;
        a_value = '0;
        b_value = '0;
        if (beat) begin
            a_value = a_in;
            b_value = b_in;
        end
    end

    // start clears the DSP accumulator both at command accept and on abort.
    assign start = accept | abort_hit;

    mac_seq_tagpipe u_tagpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .beat   (beat),
        .last   (last_beat),
        .flush  (abort_hit),
        .men    (men),
        .sen    (sen),
        .sreset (sreset)
    );

    // Control FSM with registered handshake outputs. DRAIN waits for the last
    // tag to reach stage 2 (sreset), which is the edge the DSP latches its
    // final sum, so RESULT starts exactly when s_out is valid.
    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit) begin
            state       <= IDLE;
            remaining   <= '0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // 8-bit wrap: cmd_len 0 loads 255, giving 256 beats.
                        remaining   <= cmd_len - 1'b1;
                        state       <= STREAM;
                        cmd_ready_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        if (remaining == '0) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (sreset) begin
                        state       <= RESULT;
                        res_valid_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;

    // The DSP holds s_out/sat until its next sreset; gate them so the result
    // bus is quiet outside RESULT.
    always_comb begin
        res_data = '0;
        res_sat  = 1'b0;
        if (res_valid_q) begin
            res_data = s_out;
            res_sat  = sat;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_sequencer
// Directed and randomized bench for mac_sequencer with a behavioural DSP MAC
// model attached. Expected results come from a plain-arithmetic dot product
// with 16-bit signed saturation; expected pulse timing comes from the cycles
// at which the bench itself presented each operand beat.
// -----------------------------------------------------------------------------
module tb_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] a_value;
    logic [15:0] b_value;
    logic        aen, ben, men, sen, start, sreset;
    logic [15:0] s_out;
    logic        sat;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_sat;
`ifdef MAC_SEQ_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_value   (a_value),
        .b_value   (b_value),
        .aen       (aen),
        .ben       (ben),
        .men       (men),
        .sen       (sen),
        .start     (start),
        .sreset    (sreset),
        .s_out     (s_out),
        .sat       (sat),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sat   (res_sat)
`ifdef MAC_SEQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // ---------------- behavioural DSP MAC block ----------------
    logic signed [15:0] dsp_a, dsp_b;
    logic signed [31:0] dsp_m;
    logic signed [47:0] dsp_acc;

    function automatic logic [16:0] dsp_clip(input logic signed [47:0] v);
        if (v > 48'sd32767)  return {1'b1, 16'h7FFF};
        if (v < -48'sd32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            dsp_a   <= '0;
            dsp_b   <= '0;
            dsp_m   <= '0;
            dsp_acc <= '0;
            s_out   <= '0;
            sat     <= 1'b0;
        end else begin
            if (aen) dsp_a <= $signed(a_value);
            if (ben) dsp_b <= $signed(b_value);
            if (men) dsp_m <= dsp_a * dsp_b;
            if (start) begin
                dsp_acc <= '0;
            end else if (sen) begin
                dsp_acc <= dsp_acc + dsp_m;
            end else if (sreset) begin
                {sat, s_out} <= dsp_clip(dsp_acc + dsp_m);
                dsp_acc      <= '0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: records the cycle of every DSP enable pulse.
    int men_q[$], sen_q[$], srst_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (men)    men_q.push_back(cyc);
            if (sen)    sen_q.push_back(cyc);
            if (sreset) srst_q.push_back(cyc);
            if (sen || sreset) check("one_of_sen_sreset", 32'(sen) + 32'(sreset), 32'd1);
            if (!aen) check("operands_zero_without_beat", {16'h0, a_value | b_value}, 32'd0);
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] op_a[$];
    logic [15:0] op_b[$];
    bit          vpat[$];

    function automatic logic [16:0] ref_result();
        longint sum;
        sum = 0;
        foreach (op_a[i]) sum += longint'($signed(op_a[i])) * longint'($signed(op_b[i]));
        if (sum > 32767)  return {1'b1, 16'h7FFF};
        if (sum < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(sum)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete command from the op_a/op_b/vpat tables. Entered and
    // left one time unit after a rising edge with the sequencer idle.
    task automatic run_cmd(input string name);
        int          k, sent, pi, waited, last_cyc;
        int          beat_cyc[$];
        bit          v;
        logic [16:0] exp_res;
        k = op_a.size();
        exp_res = ref_result();
        men_q.delete(); sen_q.delete(); srst_q.delete();

        // Command with in_valid already high: the beat must wait for STREAM.
        cmd_valid = 1'b1;
        cmd_len   = 8'(k);
        in_valid  = 1'b1;
        a_in      = op_a[0];
        b_in      = op_b[0];
        @(negedge clk);
        check({name, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        check({name, "_start_on_accept"}, 32'(start), 32'd1);
        check({name, "_no_beat_in_idle"}, 32'(aen), 32'd0);
        tick();
        cmd_valid = 1'b0;

        sent = 0;
        pi   = 0;
        while (sent < k) begin
            v  = (pi < vpat.size()) ? vpat[pi] : 1'b1;
            pi++;
            in_valid = v;
            if (v) begin
                a_in = op_a[sent];
                b_in = op_b[sent];
                beat_cyc.push_back(cyc);
                sent++;
            end else begin
                a_in = 16'($urandom);
                b_in = 16'($urandom);
            end
            @(negedge clk);
            check({name, "_in_ready_stream"}, 32'(in_ready), 32'd1);
            check({name, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
            check({name, "_aen_follows_valid"}, 32'(aen), 32'(v));
            if (v) check({name, "_a_value"}, 32'(a_value), 32'(op_a[sent-1]));
            tick();
        end
        in_valid = 1'b0;
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
        last_cyc = beat_cyc[k-1];

        waited = 0;
        @(negedge clk);
        while (res_valid !== 1'b1 && waited < 8) begin
            waited++;
            @(negedge clk);
        end
        check({name, "_res_valid_seen"}, 32'(res_valid), 32'd1);
        check({name, "_res_latency"}, 32'(cyc), 32'(last_cyc + 3));
        check({name, "_res_data"}, 32'(res_data), 32'(exp_res[15:0]));
        check({name, "_res_sat"}, 32'(res_sat), 32'(exp_res[16]));

        // Result must hold while not consumed.
        repeat (2) begin
            @(negedge clk);
            check({name, "_res_hold_valid"}, 32'(res_valid), 32'd1);
            check({name, "_res_hold_data"}, 32'(res_data), 32'(exp_res[15:0]));
            check({name, "_cmd_ready_result"}, 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check({name, "_cmd_ready_handshake"}, 32'(cmd_ready), 32'd0);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check({name, "_res_valid_cleared"}, 32'(res_valid), 32'd0);
        check({name, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);

        // Pulse bookkeeping against the presented beat cycles.
        check({name, "_men_count"}, 32'(men_q.size()), 32'(k));
        for (int i = 0; i < k && i < men_q.size(); i++)
            check({name, "_men_cycle"}, 32'(men_q[i]), 32'(beat_cyc[i] + 1));
        check({name, "_sen_count"}, 32'(sen_q.size()), 32'(k - 1));
        for (int i = 0; i < k - 1 && i < sen_q.size(); i++)
            check({name, "_sen_cycle"}, 32'(sen_q[i]), 32'(beat_cyc[i] + 2));
        check({name, "_sreset_count"}, 32'(srst_q.size()), 32'd1);
        if (srst_q.size() > 0) check({name, "_sreset_cycle"}, 32'(srst_q[0]), 32'(last_cyc + 2));
        tick();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({name, "_ctrl_zero"},
              32'({in_ready, aen, ben, men, sen, sreset, start, res_valid, res_sat}), 32'd0);
        check({name, "_data_zero"}, {a_value, res_data}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
        in_valid  = 1'b0;
        a_in      = 16'd0;
        b_in      = 16'd0;
        res_ready = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");
        tick();

        // K=3 dot product, no bubbles -> 32
        op_a = '{16'd1, 16'd2, 16'd3};
        op_b = '{16'd4, 16'd5, 16'd6};
        vpat.delete();
        run_cmd("k3");

        // K=1 signed -> -21
        op_a = '{16'hFFF9};
        op_b = '{16'd3};
        run_cmd("k1_neg");

        // K=4 positive overflow -> saturate
        op_a = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        op_b = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_cmd("k4_sat");

        // K=3 with bubbles 1,0,0,1,0,1
        op_a = '{16'd1, 16'd2, 16'd3};
        op_b = '{16'd4, 16'd5, 16'd6};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_cmd("k3_bubbles");

        // cmd_len=0 -> 256 beats of 1*1
        op_a.delete();
        op_b.delete();
        vpat.delete();
        for (int i = 0; i < 256; i++) begin
            op_a.push_back(16'd1);
            op_b.push_back(16'd1);
        end
        run_cmd("k256");

        // Randomized commands with random bubbles and full-range operands.
        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(1, 8);
            op_a.delete();
            op_b.delete();
            vpat.delete();
            for (int i = 0; i < k; i++) begin
                op_a.push_back(16'($urandom));
                op_b.push_back((r < 3) ? 16'($urandom_range(0, 255)) : 16'($urandom));
            end
            for (int i = 0; i < 2 * k; i++) vpat.push_back(1'($urandom_range(0, 1)));
            run_cmd("rand");
        end

        // Reset in the middle of STREAM, then a clean K=2 command -> 12
        cmd_valid = 1'b1;
        cmd_len   = 8'd4;
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        a_in      = 16'd9;
        b_in      = 16'd9;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_quiet("after_mid_reset");
        end
        tick();
        op_a = '{16'd2, 16'd2};
        op_b = '{16'd3, 16'd3};
        vpat.delete();
        run_cmd("k2_after_reset");

`ifdef MAC_SEQ_ABORT_EN
        // Abort after the first beat: no pulses survive, accumulator cleared.
        men_q.delete(); sen_q.delete(); srst_q.delete();
        cmd_valid = 1'b1;
        cmd_len   = 8'd3;
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        a_in      = 16'd7;
        b_in      = 16'd7;
        tick();
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        check("abort_start_pulse", 32'(start), 32'd1);
        check("abort_men_masked", 32'(men), 32'd0);
        tick();
        abort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_quiet("after_abort");
        end
        check("abort_no_pulses", 32'(men_q.size() + sen_q.size() + srst_q.size()), 32'd0);
        tick();
        op_a = '{16'd2, 16'd2};
        op_b = '{16'd3, 16'd3};
        run_cmd("k2_after_abort");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have cmd_valid/cmd_ready (input/output, 1 each) and cmd_len (input, 8), number of products K per command; 0 encodes 256.
REQ-004 SHALL have in_valid/in_ready (input/output, 1 each), a_in and b_in (input, 16, signed operands).
REQ-005 SHALL have outputs a_value and b_value (16), aen, ben, men, sen, start, sreset (1 each), which drive the DSP MAC block.
REQ-006 SHALL have inputs s_out (16) and sat (1), returned by the DSP.
REQ-007 SHALL have res_valid (output, 1), res_ready (input, 1), res_data (output, 16) and res_sat (output, 1).

Function
REQ-008 SHALL implement the states IDLE, STREAM, DRAIN and RESULT.
REQ-009 IDLE: cmd_ready=1; a cmd_valid&cmd_ready cycle is the accept, SHALL pulse start=1 in that same cycle, load remaining=cmd_len-1 (8-bit wrap, so 0 gives 256 beats), and move to STREAM.
REQ-010 STREAM: in_ready=1; a beat is in_valid&in_ready; on a beat aen=ben=1, a_value=a_in and b_value=b_in combinationally; remaining decrements; the beat taken with remaining==0 is tagged last and the state moves to DRAIN.
REQ-011 a_value and b_value SHALL be 0 when no beat occurs.
REQ-012 Tag pipeline: p1 <= {beat, last}; men=p1.valid; p2 <= p1.
- When p2.valid and !p2.last: sen=1.
- When p2.valid and p2.last: sreset=1.
- At most one of sen and sreset is high in any cycle.
REQ-013 Input bubbles (in_valid low) SHALL insert bubbles in men, sen and sreset only; no pulse is ever duplicated or dropped; exactly K-1 sen pulses and exactly 1 sreset pulse per command.
REQ-014 Latency: last beat at cycle L gives men at L+1 and sreset at L+2; DRAIN occupies L+1..L+2; RESULT is entered at L+3.
REQ-015 RESULT: res_valid=1, res_data=s_out, res_sat=sat (pass-through; the DSP holds them until its next sreset); the state stays until res_ready=1, then returns to IDLE.
REQ-016 cmd_ready SHALL be 0 in STREAM, DRAIN and RESULT; in_ready SHALL be 0 outside STREAM.
REQ-017 cmd_valid and in_valid may be asserted in the same cycle in IDLE; the beat is not taken until the next cycle, since in_ready=0 in IDLE.
REQ-018 res_valid and res_ready both high SHALL return the block to IDLE; a new command is accepted no earlier than the following cycle.

Reset
REQ-019 rst_n=0 at a clock edge SHALL force IDLE, remaining=0, p1=p2=0; every output is 0 except cmd_ready, which is 1 after reset is released.
REQ-020 Reset mid-operation SHALL discard the command in progress with no res_valid; the DSP shares rst_n.

Configuration
REQ-021 Macro MAC_SEQ_ABORT_EN: when defined, add input abort (1). abort=1 in STREAM or DRAIN SHALL clear p1/p2 (suppressing pending men, sen and sreset), pulse start=1 for one cycle to clear the DSP accumulator, go to IDLE, and produce no res_valid. abort in IDLE or RESULT SHALL be ignored.
REQ-022 When MAC_SEQ_ABORT_EN is not defined, the abort port and its logic SHALL be absent.

Structure
REQ-023 Package mac_seq_pkg SHALL hold the state enum, DATA_W=16, LEN_W=8 and the tag struct {valid, last}.
REQ-024 Sub-module mac_seq_tagpipe SHALL implement the 2-stage tag shift register and decode men, sen and sreset; the FSM and counter stay in the top.

Verification (bench instantiates dsp with mac_sequencer)
REQ-025 K=3, a={1,2,3}, b={4,5,6}, no bubbles -> res_data=32, res_sat=0, res_valid at last-beat+3, 2 sen and 1 sreset.
REQ-026 K=1, a=-7, b=3 -> res_data=0xFFEB, res_sat=0, 0 sen pulses.
REQ-027 K=4, a=b=0x7FFF -> res_data=0x7FFF, res_sat=1.
REQ-028 K=3 as REQ-025 with in_valid pattern 1,0,0,1,0,1 -> res_data=32, with men/sen gaps matching the bubbles.
REQ-029 cmd_len=0, 256 beats of a=b=1 -> res_data=256, res_sat=0; cmd_ready stays low until res_ready.
REQ-030 Reset mid-STREAM, then K=2, a={2,2}, b={3,3} -> res_data=12 with no stale accumulation; with MAC_SEQ_ABORT_EN, abort after beat 1, then the same command -> res_data=12.
